fifo_rd_serializer: RTL and testbench

Read-side consumer for the 16x512 dual-clock FIFO RAM. It runs in the FIFO read clock domain, pops one word at a time whenever the FIFO is not empty and draining is enabled, and shifts each word out MSB-first on a 1-bit serial line with a frame strobe and an end-of-word pulse. It accounts for the FIFO's one-cycle registered read latency and counts delivered words.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_serializer_piso.sv | 45 ++++
 rtl/fifo_rd_serializer.sv | 156 +++++++++++++++
 tb/tb_fifo_rd_serializer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the 16x512 dual-clock FIFO RAM and the state encoding
// of its read-side serializer (fifo_rd_serializer).
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;   // data word width (dout_b)
  localparam int FIFO_DEPTH = 512;  // number of words in the RAM
  localparam int ADDR       = 9;    // address width, log2(FIFO_DEPTH)

  // Read-side serializer states:
  //   ST_IDLE  - waiting for en && !empty
  //   ST_RD    - ren_b is high this cycle, FIFO samples it at the closing edge
  //   ST_LD    - FIFO read data is valid, captured at the closing edge
  //   ST_SHIFT - one bit per cycle on sdo, MSB first
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_LD    = 2'd2,
    ST_SHIFT = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_serializer_piso.sv
// -----------------------------------------------------------------------------
// piso_reg
// Parallel-in / serial-out shift register. Loads a full word, shifts left by
// one per enabled cycle (zero fill), and presents the MSB as the serial bit.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high clear
//   i_load   in   parallel load of i_din (takes priority over i_shift)
//   i_shift  in   shift left by one, LSB filled with 0
//   i_din    in   parallel data [WIDTH-1:0]
//   o_msb    out  current MSB of the register
// -----------------------------------------------------------------------------
module piso_reg
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_shreg;

  // NOTE: the shift register is a handful of flops rather than a RAM, so it
  // is cleared on reset; that keeps sdo at 0 from the reset edge onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_din;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  // Zero fill means the register is all-zero after the last bit, so sdo
  // rests at 0 between frames without extra gating.
  assign o_msb = r_shreg[WIDTH-1];

endmodule

// File: rtl/fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// fifo_rd_serializer
// Read-side consumer of the dual-clock FIFO, running in the FIFO read clock
// domain. Pops one word whenever draining is enabled and the FIFO is not
// empty, waits out the FIFO's one-cycle read latency, then shifts the word
// out MSB-first with a frame strobe and an end-of-word pulse.
//
// Ports:
//   clk       in   FIFO read clock (clk_b)
//   rst       in   synchronous active-high reset
//   en        in   drain enable, looked at only in IDLE and on the last bit
//   empty     in   FIFO empty flag, looked at only in IDLE and on the last bit
//   dout_b    in   FIFO read data, valid the cycle after ren_b is sampled
//   ren_b     out  FIFO read enable, one-cycle registered pulse per word
//   sdo       out  serial data, MSB first
//   sframe    out  high on every cycle a data bit is on sdo
//   sdone     out  one-cycle pulse on the LSB
//   word_cnt  out  words fully shifted out since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_rd_serializer #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] dout_b,
  output logic                  ren_b,
  output logic                  sdo,
  output logic                  sframe,
  output logic                  sdone,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  import fifo_pkg::*;

  localparam int BIT_W = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FIFO_WIDTH - 1);

  rd_state_e            r_state;
  rd_state_e            w_state_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic                 r_ren;
  logic                 r_sframe;
  logic                 r_sdone;

  logic w_go;
  logic w_last;
  logic w_load;
  logic w_shift;
  logic w_ren_nxt;
  logic w_sframe_nxt;
  logic w_sdone_nxt;
  logic w_sdo;

  // A new pop is only considered at the two decision points; en and empty
  // are don't-care everywhere else, so a mid-frame en drop lets the word
  // finish and an empty FIFO can never be popped.
  assign w_go   = en && !empty;
  assign w_last = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ren_nxt     = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_RD;
          w_ren_nxt   = 1'b1;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_LD;
      end
      ST_LD: begin
        // dout_b is valid now; capture it and start at the MSB.
        w_load        = 1'b1;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift       = 1'b1;
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (w_last) begin
          w_bit_cnt_nxt = '0;
          if (w_go) begin
            // Back-to-back: pop the next word straight from the last bit.
            w_state_nxt = ST_RD;
            w_ren_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame strobes are computed from the next state so they come straight
  // out of flops and line up with the bit the shift register presents.
  assign w_sframe_nxt = (w_state_nxt == ST_SHIFT);
  assign w_sdone_nxt  = w_sframe_nxt && (w_bit_cnt_nxt == LAST_BIT);

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_ren      <= 1'b0;
      r_sframe   <= 1'b0;
      r_sdone    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ren     <= w_ren_nxt;
      r_sframe  <= w_sframe_nxt;
      r_sdone   <= w_sdone_nxt;
      // Counted when the LSB leaves, so a word cut short by reset never
      // shows up in the count. Wraps naturally.
      if (w_last) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  piso_reg #(
    .WIDTH (FIFO_WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (dout_b),
    .o_msb   (w_sdo)
  );

  assign ren_b    = r_ren;
  assign sdo      = w_sdo;
  assign sframe   = r_sframe;
  assign sdone    = r_sdone;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_serializer
// Scoreboard bench: a behavioural FIFO feeds the DUT; each pushed word also
// pushes its expected frame contents and post-frame word count into a
// queue, and a monitor reassembles every serial frame and checks it.
// The word counter is narrowed to 4 bits so the wrap is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fifo_rd_serializer;

  localparam int W  = 16;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0]  word;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          en     = 1'b1;
  logic          empty  = 1'b1;
  logic [W-1:0]  dout_b = '0;
  logic          ren_b;
  logic          sdo;
  logic          sframe;
  logic          sdone;
  logic [CW-1:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0]  fifo_q[$];
  exp_t          sb_q[$];
  logic [CW-1:0] exp_cnt = '0;

  // Monitor state
  int            ren_pulses   = 0;
  int            last_ren_cyc = 0;
  logic          ren_prev     = 1'b0;
  int            mon_bits     = 0;
  logic [W-1:0]  mon_word     = '0;
  logic          cnt_pend     = 1'b0;
  logic [CW-1:0] cnt_exp      = '0;
  int            frames_seen  = 0;
  int            gap          = 0;
  int            gaps[$];

  fifo_rd_serializer #(
    .FIFO_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .dout_b   (dout_b),
    .ren_b    (ren_b),
    .sdo      (sdo),
    .sframe   (sframe),
    .sdone    (sdone),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural FIFO (one-cycle read latency) --------------
  logic ren_s = 1'b0;
  always @(negedge clk) ren_s = ren_b;

  always @(posedge clk) begin
    if (ren_s) begin
      check("pop_not_empty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) dout_b <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) begin
    #1;
    empty = (fifo_q.size() == 0);
  end

  // ---------------- monitor ------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_bits    = 0;
      mon_word    = '0;
      cnt_pend    = 1'b0;
      frames_seen = 0;
      gap         = 0;
      ren_prev    = 1'b0;
    end else begin
      if (cnt_pend) begin
        check("word_cnt_after_frame", word_cnt, cnt_exp);
        cnt_pend = 1'b0;
      end
      if (ren_b) begin
        check("ren_b_not_consecutive", ren_prev, 0);
        ren_pulses++;
        last_ren_cyc = cyc;
      end
      ren_prev = ren_b;
      if (sframe) begin
        if (mon_bits == 0) begin
          check("ren_to_msb_latency", cyc - last_ren_cyc, 2);
          if (frames_seen > 0) gaps.push_back(gap);
        end
        mon_word = {mon_word[W-2:0], sdo};
        mon_bits++;
        check("sdone_on_lsb_only", sdone, mon_bits == W);
        if (sdone) begin
          check("frame_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("frame_word", mon_word, e.word);
            cnt_exp  = e.cnt;
            cnt_pend = 1'b1;
          end
          frames_seen++;
          mon_bits = 0;
          gap      = 0;
        end
      end else begin
        if (mon_bits != 0) begin
          check("frame_length", mon_bits, W);
          mon_bits = 0;
        end
        check("sdone_outside_frame", sdone, 0);
        gap++;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    fifo_q.push_back(w);
    exp_cnt = exp_cnt + 1'b1;
    e.word  = w;
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    check("drain_done", sb_q.size(), 0);
  endtask

  task automatic wait_bits(input int nb, input int budget);
    int n = 0;
    while (mon_bits != nb && n < budget) begin
      step();
      n++;
    end
    check("bits_reached", mon_bits, nb);
  endtask

  task automatic wait_sb(input int lvl, input int budget);
    int n = 0;
    while (sb_q.size() != lvl && n < budget) begin
      step();
      n++;
    end
    check("sb_level", sb_q.size(), lvl);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    int base;

    // Reset then idle, empty FIFO with en high.
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) step();
    check("rst_ren_b", ren_b, 0);
    check("rst_sdo", sdo, 0);
    check("rst_sframe", sframe, 0);
    check("rst_sdone", sdone, 0);
    check("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    repeat (10) step();
    check("idle_no_ren", ren_pulses, 0);
    check("idle_sframe", sframe, 0);
    check("idle_word_cnt", word_cnt, 0);

    // Single word 0xA5C3.
    base = ren_pulses;
    push_word(16'hA5C3);
    drain(100);
    check("single_ren_pulses", ren_pulses - base, 1);
    check("single_word_cnt", word_cnt, 1);

    // Back-to-back three words.
    base = ren_pulses;
    gaps.delete();
    push_word(16'hFFFF);
    push_word(16'h0001);
    push_word(16'h8000);
    drain(200);
    check("b2b_ren_pulses", ren_pulses - base, 3);
    check("b2b_gap_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check("b2b_gap_1", gaps[1], 2);
      check("b2b_gap_2", gaps[2], 2);
    end
    check("b2b_idle_sframe", sframe, 0);
    check("b2b_word_cnt", word_cnt, 4);

    // Enable drop at bit 5 of 0x1234 with 0x5678 queued.
    push_word(16'h1234);
    push_word(16'h5678);
    wait_bits(5, 50);
    en = 1'b0;
    wait_sb(1, 50);
    base = ren_pulses;
    repeat (30) step();
    check("endrop_no_ren", ren_pulses - base, 0);
    check("endrop_pending", sb_q.size(), 1);
    check("endrop_sframe", sframe, 0);
    en = 1'b1;
    drain(100);
    check("endrop_resume_ren", ren_pulses - base, 1);
    check("endrop_word_cnt", word_cnt, 6);

    // Reset at bit 8 of 0xBEEF: partial word discarded and uncounted.
    fifo_q.push_back(16'hBEEF);
    wait_bits(8, 50);
    rst = 1'b1;
    step();
    check("midrst_sdo", sdo, 0);
    check("midrst_sframe", sframe, 0);
    check("midrst_sdone", sdone, 0);
    check("midrst_ren_b", ren_b, 0);
    check("midrst_word_cnt", word_cnt, 0);
    exp_cnt = '0;
    step();
    rst  = 1'b0;
    base = ren_pulses;
    push_word(16'h3C5A);
    drain(100);
    check("midrst_fresh_ren", ren_pulses - base, 1);
    check("midrst_word_cnt_after", word_cnt, 1);

    // Counter wrap: reach 2^CW-1, then one more word.
    for (int i = 1; i <= 14; i++) push_word(W'(i * 16'h1111));
    drain(14 * (W + 2) + 50);
    check("wrap_pre_max", word_cnt, 15);
    push_word(16'h8001);
    drain(100);
    check("wrap_to_zero", word_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
